// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared constants for the register file and its dump controller.
//   Special-register default addresses, FLAG gating mask, FLAG bit indices and dump FSM
//   state encoding.
package register_file_mp_pkg;
    localparam int DEF_DINP_ADDR = 28;
    localparam int DEF_GOUT_ADDR = 29;
    localparam int DEF_DOUT_ADDR = 30;
    localparam int DEF_FLAG_ADDR = 31;
    localparam logic [7:0] DEF_FLAG_GATE = 8'h2F;
    localparam int FLAG_BIT_CARRY = 0;
    localparam int FLAG_BIT_ZERO  = 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/register_file_mp_dump_ctrl.sv
// register_file_mp_dump_ctrl: valid/ready streamer that walks every register once per dump.
//   clk_i, reset_i             clock, synchronous active-high reset
//   regs_i                     flattened register array, register n at [n*DATA_W +: DATA_W]
//   start_i                    start request, honoured only in IDLE
//   valid_o / ready_i          beat handshake
//   addr_o / data_o            current beat (registered snapshot)
//   busy_o                     FSM not IDLE
//   done_o                     one-cycle pulse after the last beat
module register_file_mp_dump_ctrl
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
)(
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REGS*DATA_W-1:0] regs_i,
    input  logic                       start_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [DATA_W-1:0]          data_o,
    output logic                       busy_o,
    output logic                       done_o
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_q == ST_IDLE && start_i) begin
            state_d = ST_SCAN;
            addr_d  = '0;
            data_d  = regs_i[0 +: DATA_W];
        end else if (state_q == ST_SCAN && ready_i) begin
            if (int'(addr_q) == NUM_REGS - 1) begin
                state_d = ST_DONE;
            end else begin
                // next beat is loaded on the same edge that accepts the current one
                addr_d = ADDR_W'(int'(addr_q) + 1);
                data_d = regs_i[int'(addr_d)*DATA_W +: DATA_W];
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q <= reset_i ? ST_IDLE : state_d;
        addr_q  <= reset_i ? '0 : addr_d;
        data_q  <= reset_i ? '0 : data_d;
    end

    assign valid_o = state_q == ST_SCAN;
    assign busy_o  = state_q != ST_IDLE;
    assign done_o  = state_q == ST_DONE;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port CPU register file with special registers and debug dump.
//   clk_i, reset_i                clock, synchronous active-high reset
//   enable_i                      CPU step enable (gates writes and ATC clear)
//   long_press_i                  any bit set suppresses FLAG_GATE bits of flag_set_i
//   rd_addr_i / rd_data_o         NUM_RD packed combinational read ports
//   wr_en_i, wr_addr_i, wr_data_i single write port (FLAG not writable)
//   flag_set_i                    sticky per-bit FLAG set
//   reg_din_i                     captured into DINP every cycle
//   reg_gout_o/reg_dout_o/reg_flag_o  special register contents
//   atc_req_i, atc_bit_i, atc_out_o   atomic test-and-clear of one FLAG bit
//   dump_*                        valid/ready stream of all registers
// Optional: define REGFILE_BYPASS_EN for write-through forwarding on the read ports.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int LP_W      = 4,
    parameter int DINP_ADDR = DEF_DINP_ADDR,
    parameter int GOUT_ADDR = DEF_GOUT_ADDR,
    parameter int DOUT_ADDR = DEF_DOUT_ADDR,
    parameter int FLAG_ADDR = DEF_FLAG_ADDR,
    parameter logic [DATA_W-1:0] FLAG_GATE = DATA_W'(DEF_FLAG_GATE),
    localparam int ADDR_W = $clog2(NUM_REGS),
    localparam int BIT_W  = $clog2(DATA_W)
)(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [LP_W-1:0]          long_press_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [DATA_W-1:0]        flag_set_i,
    input  logic [DATA_W-1:0]        reg_din_i,
    output logic [DATA_W-1:0]        reg_gout_o,
    output logic [DATA_W-1:0]        reg_dout_o,
    output logic [DATA_W-1:0]        reg_flag_o,
    input  logic                     atc_req_i,
    input  logic [BIT_W-1:0]         atc_bit_i,
    output logic                     atc_out_o,
    input  logic                     dump_start_i,
    output logic                     dump_valid_o,
    input  logic                     dump_ready_i,
    output logic [ADDR_W-1:0]        dump_addr_o,
    output logic [DATA_W-1:0]        dump_data_o,
    output logic                     dump_busy_o,
    output logic                     dump_done_o
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [DATA_W-1:0] flag_set_eff, atc_clr;
    logic wr_ok, atc_hit;

    assign wr_ok = enable_i & wr_en_i & (int'(wr_addr_i) < NUM_REGS) & (int'(wr_addr_i) != FLAG_ADDR);
    assign flag_set_eff = flag_set_i & ~(FLAG_GATE & {DATA_W{|long_press_i}});
    assign atc_hit = int'(atc_bit_i) < DATA_W;
    assign atc_clr = (enable_i & atc_req_i & atc_hit) ? (DATA_W'(1) << atc_bit_i) : '0;
    assign atc_out_o = atc_req_i & atc_hit & regs_q[FLAG_ADDR][atc_bit_i];

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[wr_addr_i] = wr_data_i;
        // input capture is unconditional and beats a same-cycle CPU write
        regs_d[DINP_ADDR] = reg_din_i;
        // set is applied after clear so a same-cycle set survives test-and-clear
        regs_d[FLAG_ADDR] = (regs_q[FLAG_ADDR] & ~atc_clr) | flag_set_eff;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reset_i ? '0 : regs_d[i];
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rd_data_o[k*DATA_W +: DATA_W] = (wr_ok && wr_addr_i == a && int'(a) != DINP_ADDR) ? wr_data_i :
                                               (int'(a) < NUM_REGS) ? regs_q[a] : '0;
`else
        assign rd_data_o[k*DATA_W +: DATA_W] = (int'(a) < NUM_REGS) ? regs_q[a] : '0;
`endif
    end

    assign reg_gout_o = regs_q[GOUT_ADDR];
    assign reg_dout_o = regs_q[DOUT_ADDR];
    assign reg_flag_o = regs_q[FLAG_ADDR];

    register_file_mp_dump_ctrl #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_dump (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .regs_i (regs_flat),
        .start_i(dump_start_i),
        .ready_i(dump_ready_i),
        .valid_o(dump_valid_o),
        .addr_o (dump_addr_o),
        .data_o (dump_data_o),
        .busy_o (dump_busy_o),
        .done_o (dump_done_o)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed self-checking bench for register_file_mp (default parameters).
module tb_register_file_mp;
    logic        clk = 1'b0;
    logic        reset, enable, wr_en, atc_req, atc_out;
    logic        dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [3:0]  long_press;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic [4:0]  wr_addr, dump_addr;
    logic [7:0]  wr_data, flag_set, reg_din, reg_gout, reg_dout, reg_flag, dump_data;
    logic [2:0]  atc_bit;
    logic [7:0]  exp_r [32];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .long_press_i(long_press),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .flag_set_i(flag_set), .reg_din_i(reg_din),
        .reg_gout_o(reg_gout), .reg_dout_o(reg_dout), .reg_flag_o(reg_flag),
        .atc_req_i(atc_req), .atc_bit_i(atc_bit), .atc_out_o(atc_out),
        .dump_start_i(dump_start), .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
        .dump_addr_o(dump_addr), .dump_data_o(dump_data),
        .dump_busy_o(dump_busy), .dump_done_o(dump_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reg_din = 8'h00; rd_addr = {5'd28, 5'd0};
        do_reset();
        n_chk++; if (reg_flag !== 8'h00 || reg_gout !== 8'h00 || reg_dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_special: flag=%h gout=%h dout=%h want 00", reg_flag, reg_gout, reg_dout);
        end
        n_chk++; if (rd_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_read: got %h want 0000", rd_data);
        end
        n_chk++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_addr !== 5'd0 || dump_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_dump: v=%b b=%b d=%b a=%h dat=%h want all 0", dump_valid, dump_busy, dump_done, dump_addr, dump_data);
        end
    endtask

    task automatic test_write_read();
        write(5'd3, 8'hA5);
        rd_addr = {5'd3, 5'd3};
        #1;
        n_chk++; if (rd_data !== 16'hA5A5) begin
            n_fail++; $display("FAIL write_read: got %h want A5A5", rd_data);
        end
        write(5'd31, 8'hFF);
        n_chk++; if (reg_flag !== 8'h00) begin
            n_fail++; $display("FAIL flag_not_writable: got %h want 00", reg_flag);
        end
        write(5'd29, 8'h12);
        write(5'd30, 8'h34);
        n_chk++; if (reg_gout !== 8'h12 || reg_dout !== 8'h34) begin
            n_fail++; $display("FAIL gout_dout: got %h/%h want 12/34", reg_gout, reg_dout);
        end
    endtask

    task automatic test_flag_gate();
        long_press = 4'b0010; flag_set = 8'h21;
        step();
        n_chk++; if (reg_flag !== 8'h00) begin
            n_fail++; $display("FAIL flag_gated: got %h want 00", reg_flag);
        end
        flag_set = 8'h90;
        step();
        n_chk++; if (reg_flag !== 8'h90) begin
            n_fail++; $display("FAIL flag_ungated_bits: got %h want 90", reg_flag);
        end
        long_press = 4'b0000; flag_set = 8'h21;
        step();
        flag_set = 8'h00;
        n_chk++; if (reg_flag !== 8'hB1) begin
            n_fail++; $display("FAIL flag_no_press: got %h want B1", reg_flag);
        end
    endtask

    task automatic test_atc();
        do_reset();
        flag_set = 8'h10;
        step();
        flag_set = 8'h00; atc_bit = 3'd4; atc_req = 1'b1;
        #1;
        n_chk++; if (atc_out !== 1'b1) begin
            n_fail++; $display("FAIL atc_out_set: got %b want 1", atc_out);
        end
        step();
        n_chk++; if (reg_flag !== 8'h00 || atc_out !== 1'b0) begin
            n_fail++; $display("FAIL atc_clear: flag=%h atc_out=%b want 00/0", reg_flag, atc_out);
        end
        atc_req = 1'b0; flag_set = 8'h10;
        step();
        atc_req = 1'b1;
        step();
        flag_set = 8'h00;
        n_chk++; if (reg_flag !== 8'h10) begin
            n_fail++; $display("FAIL atc_set_wins: got %h want 10", reg_flag);
        end
        enable = 1'b0;
        step();
        n_chk++; if (reg_flag !== 8'h10 || atc_out !== 1'b1) begin
            n_fail++; $display("FAIL atc_disabled: flag=%h atc_out=%b want 10/1", reg_flag, atc_out);
        end
        atc_req = 1'b0; enable = 1'b1;
        #1;
        n_chk++; if (atc_out !== 1'b0) begin
            n_fail++; $display("FAIL atc_idle: got %b want 0", atc_out);
        end
    endtask

    task automatic test_enable();
        write(5'd5, 8'h11);
        enable = 1'b0; reg_din = 8'h77;
        write(5'd5, 8'h3C);
        enable = 1'b1; rd_addr = {5'd28, 5'd5};
        #1;
        n_chk++; if (rd_data !== 16'h7711) begin
            n_fail++; $display("FAIL enable_gate: got %h want 7711", rd_data);
        end
        reg_din = 8'h66;
        write(5'd28, 8'h55);
        n_chk++; if (rd_data !== 16'h6611) begin
            n_fail++; $display("FAIL dinp_priority: got %h want 6611", rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_b;
`ifdef REGFILE_BYPASS_EN
        exp_b = 8'h5A;
`else
        exp_b = 8'h22;
`endif
        write(5'd7, 8'h22);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h5A; rd_addr = {5'd5, 5'd7};
        #1;
        n_chk++; if (rd_data !== {8'h11, exp_b}) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", rd_data, {8'h11, exp_b});
        end
        step();
        wr_en = 1'b0;
        n_chk++; if (rd_data !== 16'h115A) begin
            n_fail++; $display("FAIL bypass_after: got %h want 115A", rd_data);
        end
    endtask

    task automatic test_dump();
        int beat, cyc, errs;
        reg_din = 8'hC3;
        do_reset();
        for (int i = 0; i < 32; i++) exp_r[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 31; i++) if (i != 28) write(5'(i), exp_r[i]);
        flag_set = 8'h42;
        step();
        flag_set = 8'h00; enable = 1'b0;
        exp_r[28] = 8'hC3; exp_r[31] = 8'h42;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        beat = 0; cyc = 0; errs = 0;
        while (beat < 32 && cyc < 200) begin
            dump_ready = cyc[0];
            if (dump_valid !== 1'b1 || dump_done !== 1'b0 || dump_addr !== 5'(beat) || dump_data !== exp_r[beat]) begin
                errs++;
                if (errs < 5) $display("FAIL dump_beat%0d: v=%b a=%0d d=%h want v=1 a=%0d d=%h", beat, dump_valid, dump_addr, dump_data, beat, exp_r[beat]);
            end
            if (dump_ready) beat++;
            cyc++;
            step();
        end
        dump_ready = 1'b0;
        n_chk++; if (errs != 0 || beat != 32) begin
            n_fail++; $display("FAIL dump_stream: %0d bad beats, %0d beats accepted, want 0 and 32", errs, beat);
        end
        n_chk++; if (dump_valid !== 1'b0 || dump_done !== 1'b1 || dump_busy !== 1'b1) begin
            n_fail++; $display("FAIL dump_done_pulse: v=%b d=%b b=%b want 0/1/1", dump_valid, dump_done, dump_busy);
        end
        step();
        n_chk++; if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            n_fail++; $display("FAIL dump_idle: d=%b b=%b want 0/0", dump_done, dump_busy);
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0; dump_ready = 1'b1;
        repeat (10) step();
        n_chk++; if (dump_valid !== 1'b1 || dump_addr !== 5'd10 || dump_data !== exp_r[10]) begin
            n_fail++; $display("FAIL dump_beat10: v=%b a=%0d d=%h want 1/10/%h", dump_valid, dump_addr, dump_data, exp_r[10]);
        end
        dump_ready = 1'b0;
        do_reset();
        n_chk++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_addr !== 5'd0) begin
            n_fail++; $display("FAIL dump_abort: v=%b b=%b a=%0d want 0/0/0", dump_valid, dump_busy, dump_addr);
        end
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable = 1'b1; long_press = 4'd0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; flag_set = '0; reg_din = '0;
        atc_req = 1'b0; atc_bit = '0; dump_start = 1'b0; dump_ready = 1'b0;
        test_reset();
        test_write_read();
        test_flag_gate();
        test_atc();
        test_enable();
        test_bypass();
        test_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
